// File: rtl/bin_erode_3x3.sv
// 3x3 binary erosion (AND of neighbourhood) on a streaming video raster.
// Define BIN_ERODE_BORDER_ZERO_EN to force every frame-border pixel to 0.
module bin_erode_3x3 #(
    parameter int H_ACT   = 1280,
    parameter int V_ACT   = 720,
    parameter int H_TOTAL = 1650,
    parameter bit VS_POL  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_in,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [23:0] data_out,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out
);

    localparam int CW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int RW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam int DL = H_TOTAL + 2;
    localparam logic [CW-1:0] COL_MAX = CW'(H_ACT - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(V_ACT - 1);

    // {vs, hs, de}; entry k carries the input timing delayed by k+1 clocks
    logic [2:0] dly_q [DL];

    logic lb1_q [H_ACT];
    logic lb2_q [H_ACT];

    logic          de_prev_q, de_prev_d;
    logic [CW-1:0] wr_col_q, wr_col_d;
    logic [CW-1:0] rd_col_q, rd_col_d;
    logic [RW-1:0] row_q, row_d;
    logic [2:0]    wm_q, wm_d;
    logic [2:0]    wl_q, wl_d;
    logic [23:0]   data_q, data_d;

    logic          de_t, de_c, de_l, vs_c;
    logic [CW-1:0] wr_addr, rd_addr;
    logic [2:0]    live, mask, col_l, col_m, col_r;
    logic          edge_t, edge_b, edge_l, edge_r, p;

    assign de_t = dly_q[H_TOTAL-1][0];
    assign de_c = dly_q[H_TOTAL][0];
    assign vs_c = dly_q[H_TOTAL][2];
    assign de_l = dly_q[H_TOTAL+1][0];

    always_comb begin
        de_prev_d = de_in;
        wr_addr   = (de_in & ~de_prev_q) ? '0 : wr_col_q;
        wr_col_d  = wr_col_q;
        if (de_in) begin
            wr_col_d = (wr_addr == COL_MAX) ? wr_addr : wr_addr + CW'(1);
        end

        // read side follows the pixel one row above the incoming one
        rd_addr  = (de_t & ~de_c) ? '0 : rd_col_q;
        rd_col_d = rd_col_q;
        if (de_t) begin
            rd_col_d = (rd_addr == COL_MAX) ? rd_addr : rd_addr + CW'(1);
        end

        row_d = row_q;
        if (vs_c == VS_POL) begin
            row_d = '0;
        end else if (de_l && !de_c && row_q != ROW_MAX) begin
            row_d = row_q + RW'(1);
        end

        // bit0 = row above centre, bit1 = centre row, bit2 = row below
        live = 3'b111;
        if (de_t) begin
            live = {de_in ? pix_in : 1'b1, lb1_q[rd_addr], lb2_q[rd_addr]};
        end

        wm_d = wm_q;
        wl_d = wl_q;
        if (de_t || de_c) begin
            wm_d = live;
            wl_d = wm_q;
        end

        edge_t = (row_q == '0);
        edge_b = (row_q == ROW_MAX);
        edge_l = ~de_l;
        edge_r = ~de_t;
        mask   = {edge_b, 1'b0, edge_t};
        col_l  = edge_l ? 3'b111 : (wl_q | mask);
        col_m  = wm_q | mask;
        col_r  = live | mask;
`ifdef BIN_ERODE_BORDER_ZERO_EN
        p = ~(edge_t | edge_b | edge_l | edge_r) & (&{col_l, col_m, col_r});
`else
        p = &{col_l, col_m, col_r};
`endif
        data_d = de_c ? {24{p}} : 24'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DL; i++) dly_q[i] <= '0;
            de_prev_q <= 1'b0;
            wr_col_q  <= '0;
            rd_col_q  <= '0;
            row_q     <= '0;
            wm_q      <= '0;
            wl_q      <= '0;
            data_q    <= '0;
        end else begin
            dly_q[0] <= {vs_in, hs_in, de_in};
            for (int i = 1; i < DL; i++) dly_q[i] <= dly_q[i-1];
            de_prev_q <= de_prev_d;
            wr_col_q  <= wr_col_d;
            rd_col_q  <= rd_col_d;
            row_q     <= row_d;
            wm_q      <= wm_d;
            wl_q      <= wl_d;
            data_q    <= data_d;
        end
    end

    // line store: contents are don't-care until written in a new frame
    always_ff @(posedge clk) begin
        if (de_in) begin
            lb1_q[wr_addr] <= pix_in;
            lb2_q[wr_addr] <= lb1_q[wr_addr];
        end
    end

    assign data_out = data_q;
    assign de_out   = dly_q[DL-1][0];
    assign hs_out   = dly_q[DL-1][1];
    assign vs_out   = dly_q[DL-1][2];

endmodule

// File: doc/bin_erode_3x3.md
BIN_ERODE_3X3 -- requirements
Module: bin_erode_3x3

Interface
REQ-001 Parameter H_ACT, default 1280: active pixels per line.
REQ-002 Parameter V_ACT, default 720: active lines per frame.
REQ-003 Parameter H_TOTAL, default 1650: total clocks per line, including blanking.
REQ-004 Parameter VS_POL, default 1: active level of vs_in.
REQ-005 clk  input  1  pixel clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 pix_in  input  1  binary pixel, 1 = white (bit 0 of upstream 24-bit binary word).
REQ-008 de_in / hs_in / vs_in  input  1 each  video timing, aligned with pix_in.
REQ-009 data_out  output  24  eroded pixel replicated, {24{p}}.
REQ-010 de_out / hs_out / vs_out  output  1 each  timing delayed to match data_out.

Function
REQ-011 The block SHALL compute, for each active pixel (c,r), p = AND of the 3x3 binary neighbourhood centred on (c,r).
REQ-012 The column counter SHALL clear on the de_in rising edge and increment per active pixel; the row counter SHALL increment on each de_in falling edge and clear while vs_in == VS_POL.
REQ-013 Two line buffers of H_ACT x 1 bit SHALL hold rows r-1 and r-2, written only when de_in = 1, addressed by the column counter.
REQ-014 A 3x3 window register SHALL shift one column per active pixel and hold its contents when de_in = 0.
REQ-015 de/hs/vs SHALL be delayed by exactly H_TOTAL+2 clocks, so that data_out for (c,r) coincides with de_out of that pixel.
REQ-016 Result for (c,r) SHALL become valid H_TOTAL+1 clocks after pix_in(c,r) and SHALL be registered once more.
REQ-017 data_out SHALL be 24'h0 whenever de_out = 0.
REQ-018 Neighbours outside the frame (c = 0, c = H_ACT-1, r = 0, r = V_ACT-1) SHALL be treated as 1 (they do not constrain the AND), unless REQ-023 applies.
REQ-019 The last line's pixels SHALL be emitted during vertical blanking using the r+1 = missing rule; the bottom row SHALL NOT wait for the next frame.
REQ-020 Counter wrap: the column counter SHALL saturate at H_ACT-1, and the row counter SHALL saturate at V_ACT-1 if more lines arrive than expected.

Reset
REQ-021 During rst_n = 0, the following SHALL be 0: all outputs, counters, window registers and sync delay lines. Line buffer contents may be undefined and SHALL NOT affect output, because the first frame's row 0 uses REQ-018.
REQ-022 A reset asserted mid-frame SHALL take effect immediately. After release, output SHALL be all-zero with de_out = 0 until the delayed timing from new input reaches the outputs.

Configuration
REQ-023 Macro BIN_ERODE_BORDER_ZERO_EN.
- Defined: every border pixel (c = 0, c = H_ACT-1, r = 0, r = V_ACT-1) SHALL output p = 0.
- Undefined: REQ-018 edge handling applies.
- Latency and ports SHALL be identical in both builds.

Verification
REQ-024 All-white frame (pix_in = 1), macro undefined -> every active data_out = 24'hFFFFFF; latency = H_TOTAL+2 clocks.
REQ-025 All-white frame, macro defined -> rows 0 and V_ACT-1 and columns 0 and H_ACT-1 = 24'h0; interior = 24'hFFFFFF.
REQ-026 White frame with a single black pixel at (100,50) -> the 3x3 block at columns 99-101, rows 49-51 = 24'h0; all other pixels = 24'hFFFFFF.
REQ-027 Isolated white 2x2 square at (10..11, 10..11) on black -> entire output frame = 24'h0.
REQ-028 rst_n pulsed low at row 300 of frame 1 -> outputs 0 immediately; frame 2 output correct per REQ-024.
REQ-029 Check hs_out/vs_out against hs_in/vs_in delayed by exactly H_TOTAL+2 clocks over 3 frames -> zero mismatches.
